// File: rtl/wb_burst_sram.sv
// Wishbone B4 registered-feedback SRAM slave with CTI/BTE bursts.
// One wait state on a first beat, zero-wait beats while a burst continues.
module wb_burst_sram #(
  parameter int ADR_WIDTH = 30,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int DEPTH     = 1024,
  parameter bit BURST_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] wishbone_adr,
  input  logic [DAT_WIDTH-1:0] wishbone_dat_w,
  output logic [DAT_WIDTH-1:0] wishbone_dat_r,
  input  logic                 wishbone_cyc,
  input  logic                 wishbone_stb,
  input  logic                 wishbone_we,
  input  logic [SEL_WIDTH-1:0] wishbone_sel,
  input  logic [2:0]           wishbone_cti,
  input  logic [1:0]           wishbone_bte,
  output logic                 wishbone_ack,
  output logic                 wishbone_err,
  output logic                 burst_active
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [ADR_WIDTH:0] DEPTH_W = (ADR_WIDTH + 1)'(DEPTH);

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic [0:0]           state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  logic                 req;
  logic                 beat;
  logic                 cont;
  logic                 rd_en;
  logic                 wr_en;
  logic [ADR_WIDTH-1:0] ra;

  function automatic logic in_range(
    input logic [ADR_WIDTH-1:0] a
  );
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Wrap modes advance only the low bits selected by the mask.
  function automatic logic [ADR_WIDTH-1:0] next_adr(
    input logic [ADR_WIDTH-1:0] a,
    input logic [1:0]           bte
  );
    logic [ADR_WIDTH-1:0] m;
    logic [ADR_WIDTH-1:0] inc;
    inc = a + ADR_WIDTH'(1);
    unique case (bte)
      2'b01:   m = ADR_WIDTH'(3);
      2'b10:   m = ADR_WIDTH'(7);
      2'b11:   m = ADR_WIDTH'(15);
      default: m = '1;
    endcase
    return (a & ~m) | (inc & m);
  endfunction

  assign req  = wishbone_cyc & wishbone_stb;
  assign beat = req & (ack_q | err_q);

  assign cont = BURST_EN &&
                ((wishbone_cti == 3'b001) ||
                 (wishbone_cti == 3'b010));

  assign wr_en = beat & wishbone_we & ack_q &
                 in_range(wishbone_adr);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_d   = err_q;
    dat_d   = dat_q;
    rd_en   = 1'b0;
    ra      = wishbone_adr;
    if (!req) begin
      ack_d   = 1'b0;
      err_d   = 1'b0;
      state_d = S_IDLE;
    end else if (beat) begin
      if (cont) begin
        state_d = S_BURST;
        rd_en   = 1'b1;
        if (wishbone_cti == 3'b010) begin
          ra = next_adr(wishbone_adr, wishbone_bte);
        end
      end else begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    end else begin
      rd_en = 1'b1;
    end
    // Prefetch: the response for the upcoming beat is registered here.
    if (rd_en) begin
      if (in_range(ra)) begin
        ack_d = 1'b1;
        err_d = 1'b0;
        dat_d = mem[ra[MW-1:0]];
      end else begin
        ack_d = 1'b0;
        err_d = 1'b1;
        dat_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (wishbone_sel[i]) begin
          mem[wishbone_adr[MW-1:0]][8*i +: 8] <=
            wishbone_dat_w[8*i +: 8];
        end
      end
    end
  end

  assign wishbone_ack   = ack_q & req;
  assign wishbone_err   = err_q & req;
  assign wishbone_dat_r = dat_q;
  assign burst_active   = (state_q == S_BURST);

endmodule

// File: tb/tb_wb_burst_sram.sv
// Bench for wb_burst_sram: transaction-level model checked every cycle,
// plus directed literal expectations.
module tb_wb_burst_sram;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          cyc, stb, we;
  logic [SW-1:0] sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack, err, ba;

  always #5 clk = ~clk;

  wb_burst_sram #(
    .ADR_WIDTH (AW),
    .DAT_WIDTH (DW),
    .SEL_WIDTH (SW),
    .DEPTH     (DEPTH),
    .BURST_EN  (1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wishbone_adr   (adr),
    .wishbone_dat_w (dat_w),
    .wishbone_dat_r (dat_r),
    .wishbone_cyc   (cyc),
    .wishbone_stb   (stb),
    .wishbone_we    (we),
    .wishbone_sel   (sel),
    .wishbone_cti   (cti),
    .wishbone_bte   (bte),
    .wishbone_ack   (ack),
    .wishbone_err   (err),
    .burst_active   (ba)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mm [DEPTH];
  logic          m_pr  = 1'b0;
  logic          m_bu  = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0;

  logic          s_ack, s_err, s_ba;
  logic [DW-1:0] s_dat;
  logic          c_ack [2];
  logic          c_err [2];
  logic [DW-1:0] c_dat;
  logic          b_ack [9];
  logic          b_err [9];
  logic          b_ba  [9];
  logic [DW-1:0] b_dat [9];

  function automatic logic inr(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] a,
    input logic [1:0]    bt
  );
    int n;
    logic [AW-1:0] off;
    case (bt)
      2'd1:    n = 4;
      2'd2:    n = 8;
      2'd3:    n = 16;
      default: n = 0;
    endcase
    if (n == 0) return a + AW'(1);
    off = a % AW'(n);
    return a - off + ((off + AW'(1)) % AW'(n));
  endfunction

  // Slave is "primed" when it holds the answer for the current beat.
  always @(posedge clk) begin : model
    logic [AW-1:0] na;
    if (reset) begin
      m_pr <= 1'b0;
      m_bu <= 1'b0;
    end else if (!(cyc && stb)) begin
      m_pr <= 1'b0;
      m_bu <= 1'b0;
    end else if (!m_pr) begin
      m_pr  <= 1'b1;
      m_adr <= adr;
      m_dat <= inr(adr) ? mm[adr[3:0]] : '0;
    end else begin
      if (cti == 3'b001 || cti == 3'b010) begin
        na = (cti == 3'b010) ? nxt(adr, bte) : adr;
        m_bu  <= 1'b1;
        m_adr <= na;
        m_dat <= inr(na) ? mm[na[3:0]] : '0;
      end else begin
        m_pr <= 1'b0;
        m_bu <= 1'b0;
      end
      if (we && inr(m_adr) && inr(adr)) begin
        for (int i = 0; i < SW; i++) begin
          if (sel[i]) mm[adr[3:0]][8*i +: 8] = dat_w[8*i +: 8];
        end
      end
    end
  end

  task automatic chk(
    input string         nm,
    input logic [DW-1:0] act,
    input logic [DW-1:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(
    input logic          s,
    input logic [AW-1:0] a,
    input logic          w,
    input logic [DW-1:0] d,
    input logic [SW-1:0] sl,
    input logic [2:0]    ct,
    input logic [1:0]    bt
  );
    logic ea, ee;
    cyc = s; stb = s; adr = a; we = w;
    dat_w = d; sel = sl; cti = ct; bte = bt;
    @(negedge clk);
    ea = cyc && stb && m_pr && inr(m_adr);
    ee = cyc && stb && m_pr && !inr(m_adr);
    s_ack = ack; s_err = err; s_ba = ba; s_dat = dat_r;
    chk("ack", DW'(ack), DW'(ea));
    chk("err", DW'(err), DW'(ee));
    chk("burst_active", DW'(ba), DW'(m_bu));
    if (ea && !we) chk("dat_r", dat_r, m_dat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 3'b000, 2'b00);
  endtask

  task automatic classic(
    input logic [AW-1:0] a,
    input logic          w,
    input logic [DW-1:0] d,
    input logic [SW-1:0] sl
  );
    drive(1'b1, a, w, d, sl, 3'b000, 2'b00);
    c_ack[0] = s_ack; c_err[0] = s_err;
    drive(1'b1, a, w, d, sl, 3'b000, 2'b00);
    c_ack[1] = s_ack; c_err[1] = s_err; c_dat = s_dat;
  endtask

  task automatic burst(
    input logic [AW-1:0] a0,
    input int            n,
    input logic          w,
    input logic [1:0]    bt,
    input logic [DW-1:0] d0
  );
    logic [AW-1:0] a;
    a = a0;
    drive(1'b1, a0, w, d0, '1,
          (n == 1) ? 3'b111 : 3'b010, bt);
    b_ack[0] = s_ack; b_err[0] = s_err;
    b_ba[0] = s_ba; b_dat[0] = s_dat;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, a, w, d0 + DW'(i), '1,
            (i == n - 1) ? 3'b111 : 3'b010, bt);
      b_ack[i+1] = s_ack; b_err[i+1] = s_err;
      b_ba[i+1] = s_ba; b_dat[i+1] = s_dat;
      a = nxt(a, bt);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    reset = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = '0; dat_w = '0;
    sel = '0; cti = '0; bte = '0;
    @(posedge clk);
    #1;
    idle();
    chk("rst_ack", DW'(s_ack), 0);
    chk("rst_err", DW'(s_err), 0);
    chk("rst_ba", DW'(s_ba), 0);
    chk("rst_dat", s_dat, 0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      classic(AW'(i), 1'b1, 32'h1000_0000 + DW'(i), '1);
    end
    idle();

    classic(5, 1'b1, 32'hDEAD_BEEF, 4'hF);
    chk("wr_ack_wait", DW'(c_ack[0]), 0);
    chk("wr_ack", DW'(c_ack[1]), 1);
    idle();
    chk("wr_ack_drop", DW'(s_ack), 0);
    classic(5, 1'b0, '0, 4'hF);
    chk("rd_ack", DW'(c_ack[1]), 1);
    chk("rd_dat5", c_dat, 32'hDEAD_BEEF);
    idle();
    chk("rd_ack_drop", DW'(s_ack), 0);

    burst(8, 4, 1'b1, 2'b00, 32'h8);
    idle();
    burst(8, 4, 1'b0, 2'b00, '0);
    chk("incr_wait", DW'(b_ack[0]), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("incr_ack", DW'(b_ack[i]), 1);
      chk("incr_dat", b_dat[i], DW'(7 + i));
    end
    chk("incr_ba", DW'(b_ba[3]), 1);
    idle();
    chk("incr_ba_drop", DW'(s_ba), 0);

    burst(14, 4, 1'b1, 2'b01, 32'hA0);
    idle();
    classic(12, 1'b0, '0, 4'hF);
    chk("wrap_wr_c", c_dat, 32'hA2);
    burst(14, 4, 1'b0, 2'b01, '0);
    for (int i = 1; i <= 4; i++) begin
      chk("wrap_dat", b_dat[i], 32'hA0 + DW'(i - 1));
    end
    idle();

    classic(3, 1'b1, 32'h1122_3344, 4'hF);
    classic(3, 1'b1, 32'h0000_AB00, 4'b0010);
    classic(3, 1'b0, '0, 4'hF);
    chk("byte_lane", c_dat, 32'h1122_AB44);
    idle();

    classic(AW'(DEPTH), 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("oor_err", DW'(c_err[1]), 1);
    chk("oor_noack", DW'(c_ack[1]), 0);
    idle();
    chk("oor_err_drop", DW'(s_err), 0);
    classic(0, 1'b0, '0, 4'hF);
    chk("oor_nowrite", c_dat, 32'h1000_0000);
    idle();

    burst(AW'(DEPTH - 2), 3, 1'b0, 2'b00, '0);
    chk("edge_ack1", DW'(b_ack[1]), 1);
    chk("edge_ack2", DW'(b_ack[2]), 1);
    chk("edge_err3", DW'(b_err[3]), 1);
    chk("edge_noack3", DW'(b_ack[3]), 0);
    chk("edge_dat1", b_dat[1], 32'hA0);
    idle();

    drive(1'b1, 8, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 8, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 9, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    drive(1'b0, 10, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    chk("stall_noack", DW'(s_ack), 0);
    drive(1'b1, 10, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    chk("stall_wait", DW'(s_ack), 0);
    drive(1'b1, 10, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    chk("stall_dat", s_dat, 32'hA);
    drive(1'b1, 11, 1'b0, '0, 4'hF, 3'b111, 2'b00);
    chk("stall_dat2", s_dat, 32'hB);
    idle();

    drive(1'b1, 8, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    drive(1'b1, 8, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    reset = 1'b1;
    drive(1'b1, 9, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    reset = 1'b0;
    drive(1'b1, 10, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    chk("mrst_ack", DW'(s_ack), 0);
    chk("mrst_err", DW'(s_err), 0);
    chk("mrst_ba", DW'(s_ba), 0);
    drive(1'b1, 10, 1'b0, '0, 4'hF, 3'b010, 2'b00);
    chk("mrst_dat", s_dat, 32'hA);
    drive(1'b1, 11, 1'b0, '0, 4'hF, 3'b111, 2'b00);
    idle();
    classic(5, 1'b0, '0, 4'hF);
    chk("mrst_keep5", c_dat, 32'hDEAD_BEEF);
    classic(9, 1'b0, '0, 4'hF);
    chk("mrst_keep9", c_dat, 32'h9);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
